// File: rtl/btn_event_arbiter.sv
// Button event arbiter: synchronise, edge-detect and hold one request per channel, then serve them round-robin over valid/ready.
// Optional overflow tracking is built when BTN_EVT_OVF_EN is defined.
module btn_event_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] btn_in,
  output logic              evt_valid,
  output logic [ID_W-1:0]   evt_id,
  input  logic              evt_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] ovf,
  input  logic              ovf_clr
);

  // state | meaning
  // IDLE  | no event offered; pick the next pending channel round-robin
  // OFFER | evt_valid high, evt_id stable until the consumer takes it
  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state, state_d;
  logic              valid_d;
  logic [ID_W-1:0]   id_d;
  logic [ID_W-1:0]   last_grant, last_grant_d;
  logic [ID_W-1:0]   sel_id;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_prev;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] hs_clr;
  logic              hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sync_prev <= '0;
    end else begin
      sync_q[0] <= btn_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise   = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign hs     = evt_valid & evt_ready;
  assign hs_clr = hs ? (NUM_CH'(1) << evt_id) : '0;

  // A new edge in the same cycle as its own clear re-arms the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~hs_clr) | rise;
  end

`ifdef BTN_EVT_OVF_EN
  logic [NUM_CH-1:0] ovf_set;
  assign ovf_set = rise & pending & ~hs_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= '0;
    else        ovf <= (ovf & ~{NUM_CH{ovf_clr}}) | ovf_set;
  end
`else
  logic ovf_clr_unused;
  assign ovf_clr_unused = ovf_clr;
  assign ovf = '0;
`endif

  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    sel_id = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (!found && pending[idx]) begin
        found  = 1'b1;
        sel_id = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      last_grant <= ID_W'(NUM_CH - 1);
    end else begin
      state      <= state_d;
      evt_valid  <= valid_d;
      evt_id     <= id_d;
      last_grant <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state;
    valid_d      = evt_valid;
    id_d         = evt_id;
    last_grant_d = last_grant;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_d = OFFER;
          valid_d = 1'b1;
          id_d    = sel_id;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_d      = IDLE;
          valid_d      = 1'b0;
          last_grant_d = evt_id;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: round-robin vector table plus hand-written latency, overflow, coincidence and reset sequences.
module tb_btn_event_arbiter;
  localparam int NUM_CH = 4;
`ifdef BTN_EVT_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_in = '0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready = 1'b0;
  logic [3:0] pending;
  logic [3:0] ovf;
  logic       ovf_clr = 1'b0;

  int tests = 0, fails = 0;
  int cyc = 0;
  int hs_count = 0, hs_first = 0, hs_last = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [3:0] press;
    int         n;
    logic [7:0] ids;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  btn_event_arbiter #(.NUM_CH(NUM_CH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .evt_valid(evt_valid),
    .evt_id(evt_id), .evt_ready(evt_ready), .pending(pending), .ovf(ovf),
    .ovf_clr(ovf_clr)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 60;
    while (budget > 0 && !(exp_q.size() == 0 && pending == 0 && !evt_valid)) begin
      tick(1);
      budget--;
    end
    if (budget == 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: queue=%0d pending=0x%0h", exp_q.size(), pending);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Handshake monitor: the offer seen here is consumed at the next posedge.
  initial forever begin
    @(negedge clk);
    if (rst_n && evt_valid && evt_ready) begin
      if (hs_count == 0) hs_first = cyc;
      hs_last = cyc;
      hs_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_evt: got id %0d expected no event", evt_id);
      end else begin
        check("evt_id", int'(evt_id), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic stable;
    vecs[0] = '{press: 4'b1011, n: 3, ids: {2'd0, 2'd3, 2'd1, 2'd0}};
    vecs[1] = '{press: 4'b1001, n: 2, ids: {2'd0, 2'd0, 2'd3, 2'd0}};
    vecs[2] = '{press: 4'b0110, n: 2, ids: {2'd0, 2'd0, 2'd2, 2'd1}};
    vecs[3] = '{press: 4'b1111, n: 4, ids: {2'd2, 2'd1, 2'd0, 2'd3}};

    tick(3);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_id", int'(evt_id), 0);
    rst_n = 1'b1;
    tick(3);

    // Single press on ch2: latency and handshake.
    btn_in[2] = 1'b1;
    tick(1); check("lat_e1_pending", int'(pending), 0);
    tick(1); check("lat_e2_pending", int'(pending), 0);
    tick(1); check("lat_e3_pending", int'(pending), 4'b0100);
    check("lat_e3_valid", int'(evt_valid), 0);
    tick(1); check("lat_e4_valid", int'(evt_valid), 1);
    check("lat_e4_id", int'(evt_id), 2);
    exp_q.push_back(2'd2);
    evt_ready = 1'b1;
    tick(1);
    check("hs_valid", int'(evt_valid), 0);
    check("hs_pending", int'(pending), 0);
    tick(5);
    btn_in = '0;
    evt_ready = 1'b0;
    tick(4);

    // Round-robin table, starting from a fresh reset so last_grant = 3.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    for (int v = 0; v < 4; v++) begin
      hs_count = 0;
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].ids[2*k +: 2]);
      evt_ready = 1'b1;
      btn_in = vecs[v].press;
      tick(3);
      btn_in = '0;
      drain();
      check($sformatf("rr%0d_count", v), hs_count, vecs[v].n);
      check($sformatf("rr%0d_spacing", v), hs_last - hs_first, 2 * (vecs[v].n - 1));
      evt_ready = 1'b0;
      tick(4);
    end

    // Held offer, then overflow by re-press while pending.
    hs_count = 0;
    btn_in[1] = 1'b1;
    tick(4);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stable &= (evt_valid === 1'b1) && (evt_id === 2'd1);
      tick(1);
    end
    check("hold_stable", int'(stable), 1);
    btn_in = '0;
    tick(4);
    btn_in[1] = 1'b1;
    tick(4);
    check("ovf_set", int'(ovf), OVF_EN ? 4'b0010 : 4'b0000);
    check("ovf_pending", int'(pending), 4'b0010);
    exp_q.push_back(2'd1);
    evt_ready = 1'b1;
    tick(6);
    check("ovf_single_evt", hs_count, 1);
    check("ovf_pending_clr", int'(pending), 0);
    evt_ready = 1'b0;
    btn_in = '0;
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clr", int'(ovf), 0);
    tick(4);

    // Re-press edge lands on the handshake cycle of the same channel.
    hs_count = 0;
    btn_in[1] = 1'b1;
    tick(4);
    check("coin_offer_id", int'(evt_id), 1);
    btn_in = '0;
    tick(4);
    btn_in[1] = 1'b1;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    tick(2);
    evt_ready = 1'b1;
    tick(1);
    check("coin_pending", int'(pending), 4'b0010);
    check("coin_ovf", int'(ovf), 0);
    check("coin_valid", int'(evt_valid), 0);
    drain();
    check("coin_count", hs_count, 2);
    btn_in = '0;
    evt_ready = 1'b0;
    tick(4);

    // Button held through reset gives exactly one event.
    rst_n = 1'b0;
    btn_in[0] = 1'b1;
    tick(3);
    rst_n = 1'b1;
    hs_count = 0;
    exp_q.push_back(2'd0);
    evt_ready = 1'b1;
    tick(20);
    check("held_rst_count", hs_count, 1);
    check("held_rst_pending", int'(pending), 0);
    evt_ready = 1'b0;

    // Asynchronous reset in the middle of an offer.
    btn_in = '0;
    tick(4);
    btn_in[0] = 1'b1;
    tick(4);
    btn_in = '0;
    tick(4);
    btn_in[0] = 1'b1;
    tick(4);
    check("pre_rst_valid", int'(evt_valid), 1);
    check("pre_rst_ovf", int'(ovf), OVF_EN ? 4'b0001 : 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(evt_valid), 0);
    check("async_rst_pending", int'(pending), 0);
    check("async_rst_ovf", int'(ovf), 0);
    btn_in = '0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Collects rising-edge events from NUM_CH asynchronous push-button inputs, holds one pending request per channel, and serves them one at a time to a single downstream consumer over a valid/ready handshake with round-robin fairness. It sits between the board buttons and the control logic that acts on presses, so no press is lost when several buttons are pressed close together. It synchronises, edge-detects, queues and arbitrates every input.

## Interface
- NUM_CH, 4, number of button channels (2..16); ID_W = $clog2(NUM_CH) is a localparam.
- SYNC_STAGES, 2, synchroniser depth per channel (2..4).

- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_in  in  NUM_CH  raw asynchronous button levels, active-high.
- evt_valid  out  1  an event is being offered.
- evt_id  out  ID_W  channel index of the offered event.
- evt_ready  in  1  consumer accepts the offered event.
- pending  out  NUM_CH  per-channel pending request flags (registered).
- ovf  out  NUM_CH  sticky per-channel overflow flags.
- ovf_clr  in  1  synchronous clear of all ovf bits.

## Operation
- Reset (rst_n low, asynchronous): sync chains, previous-level registers, pending, ovf, evt_valid, evt_id all 0; state IDLE; last_grant = NUM_CH-1, so channel 0 has first priority.
- Per channel: btn_in[i] passes a SYNC_STAGES-flop chain. The rising edge is sync_out & ~sync_prev, where sync_prev is the registered previous sync_out. A button held high through reset therefore yields exactly one event after release of reset.
- Rising edge sets pending[i] on the next clk.
- FSM IDLE: if any pending bit is set, select the first set bit searching upward from last_grant+1 with wrap modulo NUM_CH. Register it into evt_id, assert evt_valid and go to OFFER. Otherwise stay.
- FSM OFFER: evt_valid=1 and evt_id stays stable until evt_ready=1. On the handshake cycle (evt_valid & evt_ready):
  - clear pending[evt_id];
  - set last_grant = evt_id;
  - deassert evt_valid;
  - return to IDLE.
- Falling edges are ignored.
- Overflow: a rising edge on channel i while pending[i]=1, and not in the same cycle as its handshake clear, sets ovf[i]. The event merges into the existing request. ovf_clr=1 clears all ovf bits. A simultaneous set and clear leaves the bit set.
- Simultaneous handshake clear of pending[i] and a new rising edge on i: pending[i] stays 1, no overflow.
- evt_ready while evt_valid=0 is ignored.

## Timing
- Edge-to-offer latency: with edge 1 being the first clk edge that samples btn_in high, pending rises after edge SYNC_STAGES+1 and evt_valid after edge SYNC_STAGES+2 (4 cycles for the default).
- Maximum throughput is one event per 2 cycles (OFFER->IDLE->OFFER); evt_valid is low for at least 1 cycle between events.
- All outputs are registered; no combinational path from evt_ready to any output.
- The arbiter selection is combinational from pending and last_grant within IDLE only.

## Configuration
- BTN_EVT_OVF_EN defined: overflow detection as described; ovf is sticky and cleared by ovf_clr.
- Not defined: no overflow logic is built; ovf is tied to 0 and ovf_clr is ignored. Merge behaviour of a repeated edge into an existing pending bit is unchanged.

## Test plan
- Reset with btn_in=4'b0000, release, press ch2 (hold 10 cycles) -> pending[2] after edge 3, evt_valid=1 with evt_id=2 after edge 4. evt_ready=1 -> pending=0, evt_valid=0 next cycle.
- Press ch0, ch1 and ch3 in the same cycle, evt_ready held 1 -> evt_id sequence 0,1,3, each offer 2 cycles apart. Then press ch0 and ch3 again -> next sequence 0,3 (round-robin from last_grant=3).
- Press ch1, keep evt_ready=0 for 20 cycles -> evt_valid and evt_id=1 stay stable. Release, re-press ch1 -> ovf[1]=1 and pending stays 1. evt_ready=1 -> one event only. Pulse ovf_clr -> ovf=0.
- Re-press ch1 timed so its sync edge coincides with the handshake of the ch1 event -> pending[1] remains 1, ovf[1]=0, a second ch1 event is offered.
- Hold btn_in[0]=1 through reset -> exactly one ch0 event after reset release. Assert rst_n low mid-OFFER -> evt_valid, pending and ovf go 0 immediately, without waiting for a clk edge.
- Build without BTN_EVT_OVF_EN, repeat the overflow scenario -> ovf stays 0, single merged ch1 event.
